// File: rtl/stack_ptr_ctrl.sv
// stack_ptr_ctrl: full-descending stack pointer controller with burst push/pop.
// A push writes at sp and then decrements sp. A pop increments sp and then
// reads at the new sp. Requests are accepted only in IDLE, and an accepted
// request runs as one access per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                qualifies push/pop/load
//   push, pop, count  request type and word count (1..MAXBURST)
//   load, load_val    load sp directly (priority over push/pop)
//   err_clr           clears sticky ovf/unf
//   sp                current stack pointer
//   addr              access address (0 when idle)
//   mem_we, mem_re    per-word write/read strobes
//   busy, done        burst in progress / last access of burst
//   ovf, unf          sticky overflow/underflow flags
module stack_ptr_ctrl #(
    parameter int unsigned AW       = 32,
    parameter int unsigned TOP      = 2047,
    parameter int unsigned BOTTOM   = 1024,
    parameter int unsigned MAXBURST = 2,
    localparam int unsigned CW      = $clog2(MAXBURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic [CW-1:0] count,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          err_clr,
    output logic [AW-1:0] sp,
    output logic [AW-1:0] addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          unf
);

    typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] rem, rem_n;
    logic [AW-1:0] sp_n, addr_n;
    logic          mem_we_n, mem_re_n, busy_n, done_n, ovf_n, unf_n;
    logic          set_ovf, set_unf, req_ok;

    // Range checks widened so neither side can wrap.
    // Push fits when sp+1 >= BOTTOM+count, i.e. sp-count+1 >= BOTTOM.
    logic [AW+1:0] push_lo, push_hi;
    logic [AW:0]   pop_end;

    assign push_lo = (AW+2)'(sp) + (AW+2)'(1);
    assign push_hi = (AW+2)'(BOTTOM) + (AW+2)'(count);
    assign pop_end = (AW+1)'(sp) + (AW+1)'(count);
    assign req_ok  = (push ^ pop) && (count != '0) && (count <= CW'(MAXBURST));

    // Next-state, pointer, flag and output computation
    always_comb begin
        state_n = state;
        rem_n   = rem;
        sp_n    = sp;
        set_ovf = 1'b0;
        set_unf = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    if (load) begin
                        sp_n = load_val;
                    end else if (req_ok && push) begin
                        if (push_lo >= push_hi) begin
                            state_n = PUSH;
                            rem_n   = count;
                        end else begin
                            set_ovf = 1'b1;
                        end
                    end else if (req_ok && pop) begin
                        if (pop_end <= (AW+1)'(TOP)) begin
                            state_n = POP;
                            rem_n   = count;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                end
            end
            PUSH: begin
                sp_n  = sp - AW'(1);
                rem_n = rem - CW'(1);
                if (rem == CW'(1)) state_n = IDLE;
            end
            POP: begin
                sp_n  = sp + AW'(1);
                rem_n = rem - CW'(1);
                if (rem == CW'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A new error in the same cycle wins over err_clr
        ovf_n = err_clr ? 1'b0 : ovf;
        unf_n = err_clr ? 1'b0 : unf;
        if (set_ovf) ovf_n = 1'b1;
        if (set_unf) unf_n = 1'b1;

        // Outputs are registered and describe the access of the coming cycle
        mem_we_n = (state_n == PUSH);
        mem_re_n = (state_n == POP);
        busy_n   = (state_n != IDLE);
        done_n   = (state_n != IDLE) && (rem_n == CW'(1));
        addr_n   = '0;
        if (state_n == PUSH) addr_n = sp_n;
        if (state_n == POP)  addr_n = sp_n + AW'(1);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            sp     <= AW'(TOP);
            addr   <= '0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            sp     <= sp_n;
            addr   <= addr_n;
            mem_we <= mem_we_n;
            mem_re <= mem_re_n;
            busy   <= busy_n;
            done   <= done_n;
            ovf    <= ovf_n;
            unf    <= unf_n;
        end
    end

endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// tb_stack_ptr_ctrl: directed-vector bench. Expected memory accesses go into a
// scoreboard queue; a monitor pops and compares on every strobe. Pointer and
// flag state is compared directly after each scenario.
module tb_stack_ptr_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst, en, push, pop, load, err_clr;
    logic [CW-1:0] count;
    logic [AW-1:0] load_val;
    logic [AW-1:0] sp, addr;
    logic          mem_we, mem_re, busy, done, ovf, unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          re;
        logic          done;
    } acc_t;

    acc_t exp_q[$];

    stack_ptr_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .count(count),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .sp(sp), .addr(addr), .mem_we(mem_we), .mem_re(mem_re),
        .busy(busy), .done(done), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe must match the next expected access
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_access: addr=%0d we=%0b re=%0b done=%0b, none expected",
                         addr, mem_we, mem_re, done);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                if (addr !== e.addr || mem_we !== e.we || mem_re !== e.re || done !== e.done) begin
                    failures++;
                    $display("FAIL access: got addr=%0d we=%0b re=%0b done=%0b, expected addr=%0d we=%0b re=%0b done=%0b",
                             addr, mem_we, mem_re, done, e.addr, e.we, e.re, e.done);
                end
            end
        end else if (done || addr != '0) begin
            checks++;
            failures++;
            $display("FAIL idle_outputs: got addr=%0d done=%0b, expected 0 and 0", addr, done);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; push = 0; pop = 0; load = 0; err_clr = 0; count = '0; load_val = '0;
    endtask

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_acc(input logic [AW-1:0] a, input logic we, input logic dn);
        acc_t e;
        e.addr = a; e.we = we; e.re = ~we; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic request(input logic is_push, input logic is_pop, input logic [CW-1:0] n);
        en = 1; push = is_push; pop = is_pop; count = n;
        cycle();
        idle_inputs();
    endtask

    task automatic check_status(input string tag, input logic [AW-1:0] esp,
                                input logic eovf, input logic eunf);
        check({tag, "_sp"},   sp, esp);
        check({tag, "_busy"}, AW'(busy), '0);
        check({tag, "_ovf"},  AW'(ovf),  AW'(eovf));
        check({tag, "_unf"},  AW'(unf),  AW'(eunf));
    endtask

    task automatic do_load(input logic [AW-1:0] v);
        en = 1; load = 1; load_val = v;
        cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        check_status("reset", 2047, 0, 0);
        check("reset_we", AW'(mem_we), '0);
        check("reset_re", AW'(mem_re), '0);

        // Push 2 from the top
        expect_acc(2047, 1, 0);
        expect_acc(2046, 1, 1);
        request(1, 0, 2);
        check("push2_busy", AW'(busy), 1);
        cycle(); cycle();
        check_status("push2", 2045, 0, 0);

        // Pop 2 back to the top (exact upper boundary)
        expect_acc(2046, 0, 0);
        expect_acc(2047, 0, 1);
        request(0, 1, 2);
        cycle(); cycle();
        check_status("pop2", 2047, 0, 0);

        // Pop at the top underflows
        request(0, 1, 1);
        cycle();
        check_status("underflow", 2047, 0, 1);
        err_clr = 1; cycle(); idle_inputs();
        check_status("unf_clear", 2047, 0, 0);

        // Load near the bottom, push to the limit, then overflow
        do_load(1025);
        check_status("load", 1025, 0, 0);
        expect_acc(1025, 1, 0);
        expect_acc(1024, 1, 1);
        request(1, 0, 2);
        cycle(); cycle();
        check_status("push_bottom", 1023, 0, 0);
        request(1, 0, 1);
        cycle();
        check_status("overflow", 1023, 1, 0);

        // Overflow setting in the same cycle as err_clr keeps the flag
        err_clr = 1;
        request(1, 0, 2);
        check_status("set_wins", 1023, 1, 0);
        err_clr = 1; cycle(); idle_inputs();
        check_status("ovf_clear", 1023, 0, 0);

        // Single push exactly at BOTTOM is accepted
        do_load(1024);
        expect_acc(1024, 1, 1);
        request(1, 0, 1);
        cycle();
        check_status("push_exact", 1023, 0, 0);

        // Push+pop together and count=0 are ignored
        request(1, 1, 1);
        cycle();
        check_status("both", 1023, 0, 0);
        request(0, 1, 0);
        cycle();
        check_status("count0", 1023, 0, 0);

        // Load while busy is ignored
        expect_acc(1024, 0, 0);
        expect_acc(1025, 0, 1);
        request(0, 1, 2);
        en = 1; load = 1; load_val = 77;
        cycle();
        idle_inputs();
        cycle();
        check_status("load_busy", 1025, 0, 0);

        // Reset during the first access cycle aborts the burst
        rst = 1; cycle(); rst = 0;
        expect_acc(2047, 1, 0);
        request(1, 0, 2);
        rst = 1;
        cycle();
        rst = 0;
        check_status("rst_abort", 2047, 0, 0);
        check("rst_abort_we", AW'(mem_we), '0);
        cycle(); cycle();
        check("rst_abort_sp_hold", sp, 2047);

        check("scoreboard_empty", AW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
